// File: rtl/instr_queue_expander.sv
// Instruction-queue FIFO that expands each entry into copy_count strided micro-ops.
// Program-end markers are consumed at the head and reported as a program_complete pulse.
module instr_queue_expander #(
  parameter int DEPTH_LOG2            = 4,
  parameter int LOG_SUPERSCALAR_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push_we,
  input  logic [1:0]                       push_instr_type,
  input  logic [LOG_SUPERSCALAR_WIDTH:0]   push_copy_count,
  input  logic [17:0]                      push_cache_addr,
  input  logic [17:0]                      push_main_mem_addr,
  input  logic [17:0]                      push_d_cache_addr,
  input  logic [17:0]                      push_d_main_mem_addr,
  input  logic [8:0]                       push_arith_instr,
  input  logic [2:0]                       push_ram_instr,
  input  logic [6:0]                       push_ld_st_instr,
  output logic                             stall_push,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [1:0]                       out_instr_type,
  output logic [17:0]                      out_cache_addr,
  output logic [17:0]                      out_main_mem_addr,
  output logic [8:0]                       out_arith_instr,
  output logic [2:0]                       out_ram_instr,
  output logic [6:0]                       out_ld_st_instr,
  output logic [LOG_SUPERSCALAR_WIDTH-1:0] out_copy_index,
  output logic                             program_complete,
  output logic                             overflow_error
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = LOG_SUPERSCALAR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_COPIES = CW'(1) << LOG_SUPERSCALAR_WIDTH;

  typedef struct packed {
    logic [1:0]    instr_type;
    logic [CW-1:0] copies;
    logic [17:0]   cache_addr;
    logic [17:0]   main_mem_addr;
    logic [17:0]   d_cache_addr;
    logic [17:0]   d_main_mem_addr;
    logic [8:0]    arith;
    logic [2:0]    ram;
    logic [6:0]    ld_st;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, EXPAND, END} state_t;

  entry_t                           mem [DEPTH];
  logic [DEPTH_LOG2-1:0]            wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [DEPTH_LOG2:0]              count_reg;
  logic [LOG_SUPERSCALAR_WIDTH-1:0] k_reg;
  logic [17:0]                      acc_cache_reg, acc_main_reg;
  state_t                           state_reg;
  logic                             out_valid_reg, program_complete_reg, overflow_reg;

  entry_t push_entry, head, new_head;
  logic   fire, last, pop, full, push_ok, load_head;

  // Copy counts are normalised once on entry so the head logic only sees 1..MAX_COPIES.
  always_comb begin
    push_entry.instr_type      = push_instr_type;
    push_entry.copies          = push_copy_count;
    if (push_copy_count == '0)
      push_entry.copies = CW'(1);
    else if (push_copy_count > MAX_COPIES)
      push_entry.copies = MAX_COPIES;
    push_entry.cache_addr      = push_cache_addr;
    push_entry.main_mem_addr   = push_main_mem_addr;
    push_entry.d_cache_addr    = push_d_cache_addr;
    push_entry.d_main_mem_addr = push_d_main_mem_addr;
    push_entry.arith           = push_arith_instr;
    push_entry.ram             = push_ram_instr;
    push_entry.ld_st           = push_ld_st_instr;
  end

  assign head       = mem[rd_ptr_reg];
  assign rd_ptr_inc = rd_ptr_reg + DEPTH_LOG2'(1);
  assign fire       = out_valid_reg & out_ready;
  assign last       = (CW'(k_reg) == head.copies - CW'(1));
  assign pop        = ((state_reg == EXPAND) && fire && last) || (state_reg == END);
  assign full       = (count_reg == (DEPTH_LOG2+1)'(DEPTH));
  assign push_ok    = push_we && (!full || pop);

  // The next head comes from the queue if one is waiting, else straight from this push.
  always_comb begin
    load_head = 1'b0;
    new_head  = push_entry;
    if (pop) begin
      if (count_reg > (DEPTH_LOG2+1)'(1)) begin
        load_head = 1'b1;
        new_head  = mem[rd_ptr_inc];
      end else if (push_ok) begin
        load_head = 1'b1;
      end
    end else if ((state_reg == EMPTY) && push_ok) begin
      load_head = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg           <= '0;
      rd_ptr_reg           <= '0;
      count_reg            <= '0;
      k_reg                <= '0;
      acc_cache_reg        <= '0;
      acc_main_reg         <= '0;
      state_reg            <= EMPTY;
      out_valid_reg        <= 1'b0;
      program_complete_reg <= 1'b0;
      overflow_reg         <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_inc;
      unique case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + (DEPTH_LOG2+1)'(1);
        2'b01:   count_reg <= count_reg - (DEPTH_LOG2+1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (push_we && !push_ok)
        overflow_reg <= 1'b1;
      program_complete_reg <= (state_reg == END);

      if (load_head) begin
        state_reg     <= (new_head.instr_type == 2'd3) ? END : EXPAND;
        out_valid_reg <= (new_head.instr_type != 2'd3);
        k_reg         <= '0;
        acc_cache_reg <= new_head.cache_addr;
        acc_main_reg  <= new_head.main_mem_addr;
      end else if (pop) begin
        state_reg     <= EMPTY;
        out_valid_reg <= 1'b0;
        k_reg         <= '0;
      end else if ((state_reg == EXPAND) && fire) begin
        k_reg         <= k_reg + LOG_SUPERSCALAR_WIDTH'(1);
        acc_cache_reg <= acc_cache_reg + head.d_cache_addr;
        acc_main_reg  <= acc_main_reg + head.d_main_mem_addr;
      end
    end
  end

  assign stall_push        = (count_reg >= (DEPTH_LOG2+1)'(DEPTH - 2));
  assign out_valid         = out_valid_reg;
  assign out_instr_type    = head.instr_type;
  assign out_cache_addr    = acc_cache_reg;
  assign out_main_mem_addr = acc_main_reg;
  assign out_arith_instr   = head.arith;
  assign out_ram_instr     = head.ram;
  assign out_ld_st_instr   = head.ld_st;
  assign out_copy_index    = k_reg;
  assign program_complete  = program_complete_reg;
  assign overflow_error    = overflow_reg;
endmodule
